// File: rtl/ring_phase_monitor.sv
// Watches a 4-bit one-hot ring counter, reports its phase, counts completed
// rotations and latches the first sequencing error until software clears it.
module ring_phase_monitor #(
  parameter int ROT_W = 8
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic [3:0]       in_q,
  input  logic             in_clr_err,
  output logic [1:0]       o_phase,
  output logic             o_valid,
  output logic [ROT_W-1:0] o_rot_cnt,
  output logic             o_err,
  output logic [1:0]       o_err_code,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK  = 2'd1,
    TRACK = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_NOT_ONE = 2'b01;
  localparam logic [1:0] CODE_SKIP    = 2'b10;

  state_t     state;
  logic [3:0] prev_q;

  logic       one_hot;
  logic       is_hold;
  logic       is_adv;
  logic       is_wrap;
  logic [1:0] enc;

  // Handshake: o_valid qualifies o_phase for the sample taken on the previous
  // edge; there is no back-pressure, so every cycle produces a fresh result.
  always_comb begin
    one_hot = (in_q != 4'b0000) && ((in_q & (in_q - 4'd1)) == 4'b0000);
    is_hold = (in_q == prev_q);
    is_adv  = (in_q == {prev_q[2:0], prev_q[3]});
    is_wrap = (prev_q == 4'b1000) && (in_q == 4'b0001);
    enc     = 2'd0;
    case (in_q)
      4'b0010: enc = 2'd1;
      4'b0100: enc = 2'd2;
      4'b1000: enc = 2'd3;
      default: enc = 2'd0;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state      <= IDLE;
      prev_q     <= 4'b0000;
      o_phase    <= 2'd0;
      o_valid    <= 1'b0;
      o_rot_cnt  <= '0;
      o_err      <= 1'b0;
      o_err_code <= CODE_NONE;
    end else begin
      case (state)
        IDLE: begin
          // Garbage before the ring starts is tolerated, not flagged.
          if (one_hot) begin
            state   <= LOCK;
            prev_q  <= in_q;
            o_phase <= enc;
            o_valid <= 1'b1;
          end else begin
            o_valid <= 1'b0;
          end
        end
        LOCK, TRACK: begin
          if (!one_hot) begin
            state      <= ERROR;
            o_valid    <= 1'b0;
            o_err      <= 1'b1;
            o_err_code <= CODE_NOT_ONE;
          end else if (is_hold) begin
            o_valid <= 1'b1;
          end else if (is_adv) begin
            state   <= TRACK;
            prev_q  <= in_q;
            o_phase <= enc;
            o_valid <= 1'b1;
            if (state == TRACK && is_wrap) begin
              o_rot_cnt <= o_rot_cnt + 1'b1;
            end
          end else begin
            state      <= ERROR;
            o_valid    <= 1'b0;
            o_err      <= 1'b1;
            o_err_code <= CODE_SKIP;
          end
        end
        ERROR: begin
          // Sample is not classified here; phase and count stay frozen.
          o_valid <= 1'b0;
          if (in_clr_err) begin
            state      <= IDLE;
            o_err      <= 1'b0;
            o_err_code <= CODE_NONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Randomized and directed bench for ring_phase_monitor; two instances (wide and
// 2-bit rotation counter) share stimulus and are checked against one model.
module tb_ring_phase_monitor;

  logic       in_clk;
  logic       in_rst_n;
  logic [3:0] in_q;
  logic       in_clr_err;

  logic [1:0] a_phase, b_phase;
  logic       a_valid, b_valid;
  logic [7:0] a_rot;
  logic [1:0] b_rot;
  logic       a_err, b_err;
  logic [1:0] a_code, b_code;
  logic [1:0] a_state, b_state;

  int checks = 0;
  int errors = 0;

  // expected word: phase[17:16] valid[15] cnt8[14:7] cnt2[6:5] err[4] code[3:2] state[1:0]
  logic [17:0] exp_q[$];

  // reference model, phases as integers 0..3
  int m_state, m_prev, m_phase, m_valid, m_cnt, m_err, m_code;

  ring_phase_monitor #(.ROT_W(8)) dut_a (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_q(in_q), .in_clr_err(in_clr_err),
    .o_phase(a_phase), .o_valid(a_valid), .o_rot_cnt(a_rot), .o_err(a_err),
    .o_err_code(a_code), .o_state(a_state)
  );

  ring_phase_monitor #(.ROT_W(2)) dut_b (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_q(in_q), .in_clr_err(in_clr_err),
    .o_phase(b_phase), .o_valid(b_valid), .o_rot_cnt(b_rot), .o_err(b_err),
    .o_err_code(b_code), .o_state(b_state)
  );

  // clock / reset
  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ph_of(input logic [3:0] q);
    for (int i = 0; i < 4; i++) if (q[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_prev = -1; m_phase = 0; m_valid = 0;
    m_cnt = 0; m_err = 0; m_code = 0;
  endtask

  task automatic model_step(input logic [3:0] q, input logic clr);
    int p;
    p = ph_of(q);
    if (m_state == 3) begin
      m_valid = 0;
      if (clr) begin
        m_state = 0; m_err = 0; m_code = 0;
      end
    end else if ($countones(q) != 1) begin
      m_valid = 0;
      if (m_state != 0) begin
        m_state = 3; m_err = 1; m_code = 1;
      end
    end else if (m_state == 0) begin
      m_state = 1; m_prev = p; m_phase = p; m_valid = 1;
    end else if (p == m_prev) begin
      m_valid = 1;
    end else if (p == (m_prev + 1) % 4) begin
      if (m_state == 2 && p == 0) m_cnt++;
      m_state = 2; m_prev = p; m_phase = p; m_valid = 1;
    end else begin
      m_state = 3; m_err = 1; m_code = 2; m_valid = 0;
    end
  endtask

  task automatic push_exp();
    logic [17:0] e;
    e = {m_phase[1:0], m_valid[0], m_cnt[7:0], m_cnt[1:0], m_err[0], m_code[1:0], m_state[1:0]};
    exp_q.push_back(e);
  endtask

  // driver
  task automatic step(input logic [3:0] q, input logic clr);
    @(negedge in_clk);
    in_q = q;
    in_clr_err = clr;
    model_step(q, clr);
    push_exp();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_phase_a"}, a_phase, 0);  chk({tag, "_phase_b"}, b_phase, 0);
    chk({tag, "_valid_a"}, a_valid, 0);  chk({tag, "_valid_b"}, b_valid, 0);
    chk({tag, "_rot_a"}, a_rot, 0);      chk({tag, "_rot_b"}, b_rot, 0);
    chk({tag, "_err_a"}, a_err, 0);      chk({tag, "_err_b"}, b_err, 0);
    chk({tag, "_code_a"}, a_code, 0);    chk({tag, "_code_b"}, b_code, 0);
    chk({tag, "_state_a"}, a_state, 0);  chk({tag, "_state_b"}, b_state, 0);
  endtask

  // asynchronous reset in the middle of the clock-high phase
  task automatic async_reset(input string tag);
    @(posedge in_clk);
    #3;
    in_rst_n = 1'b0;
    #1;
    check_reset(tag);
    model_reset();
    exp_q.delete();
    @(negedge in_clk);
    in_q = 4'b0000;
    in_clr_err = 1'b0;
    in_rst_n = 1'b1;
  endtask

  // scoreboard monitor
  always @(posedge in_clk) begin
    logic [17:0] e;
    #1;
    if (in_rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("phase_a", a_phase, e[17:16]);  chk("phase_b", b_phase, e[17:16]);
      chk("valid_a", a_valid, e[15]);     chk("valid_b", b_valid, e[15]);
      chk("rot_a", a_rot, e[14:7]);       chk("rot_b", b_rot, e[6:5]);
      chk("err_a", a_err, e[4]);          chk("err_b", b_err, e[4]);
      chk("code_a", a_code, e[3:2]);      chk("code_b", b_code, e[3:2]);
      chk("state_a", a_state, e[1:0]);    chk("state_b", b_state, e[1:0]);
    end
  end

  initial begin
    logic [3:0] q;
    logic       clr;
    int         r;

    in_rst_n = 1'b0;
    in_q = 4'b0000;
    in_clr_err = 1'b0;
    model_reset();
    repeat (3) @(posedge in_clk);
    #1;
    check_reset("por");
    @(negedge in_clk);
    in_rst_n = 1'b1;

    // start-up garbage tolerated
    repeat (3) step(4'b0000, 1'b0);

    // three clean rotations
    for (int rr = 0; rr < 3; rr++)
      for (int i = 0; i < 4; i++) begin
        q = 4'b0001 << i;
        step(q, 1'b0);
      end
    step(4'b0001, 1'b0);

    // skip error, then a second fault must not overwrite the code
    step(4'b0010, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b0110, 1'b0);

    // clear, relock
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);

    async_reset("rst_track");

    // five rotations to wrap the narrow counter
    step(4'b0001, 1'b0);
    for (int rr = 0; rr < 5; rr++)
      for (int i = 1; i <= 4; i++) begin
        q = 4'b0001 << (i % 4);
        step(q, 1'b0);
      end

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 99);
      clr = ($urandom_range(0, 99) < 10);
      if (m_state == 3) begin
        clr = (r < 30);
        q = 4'($urandom_range(0, 15));
      end else if (r < 65) begin
        q = (m_state == 0) ? 4'b0001 << $urandom_range(0, 3) : 4'b0001 << ((m_prev + 1) % 4);
      end else if (r < 80) begin
        q = (m_prev < 0) ? 4'b0001 : 4'b0001 << m_prev;
      end else if (r < 90) begin
        q = 4'($urandom_range(0, 15));
      end else begin
        q = 4'b0001 << $urandom_range(0, 3);
      end
      step(q, clr);
    end

    // reset while in ERROR
    async_reset("rst_pre_err");
    step(4'b0001, 1'b0);
    step(4'b0100, 1'b0);
    async_reset("rst_err");

    @(posedge in_clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_phase_monitor.md
RING_PHASE_MONITOR -- requirements
Module: ring_phase_monitor

Interface
REQ-001 The block SHALL have one parameter: ROT_W, default 8, width of the rotation counter.
REQ-002 The block SHALL have port in_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port in_rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port in_q, input, 4, one-hot ring counter output; legal sequence 0001->0010->0100->1000->0001.
REQ-005 The block SHALL have port in_clr_err, input, 1, synchronous clear of the error condition.
REQ-006 The block SHALL have port o_phase, output, 2, encoded phase of the last accepted sample.
REQ-007 The block SHALL have port o_valid, output, 1, o_phase qualifier.
REQ-008 The block SHALL have port o_rot_cnt, output, ROT_W, count of completed rotations.
REQ-009 The block SHALL have port o_err, output, 1, sticky error flag.
REQ-010 The block SHALL have port o_err_code, output, 2: 00 none, 01 not one-hot, 10 illegal step.
REQ-011 The block SHALL have port o_state, output, 2: IDLE=0, LOCK=1, TRACK=2, ERROR=3.

Function
REQ-012 The block SHALL sample in_q every rising in_clk; all outputs are registered and reflect that sample one cycle later.
REQ-013 The block SHALL hold a previous-sample register of the last accepted one-hot value.
REQ-014 Phase encoding SHALL be 0001->0, 0010->1, 0100->2, 1000->3.
REQ-015 Classification SHALL be: invalid = bit count != 1, including 0000; hold = equal to previous; advance = next in the legal sequence; skip = any other one-hot value.
REQ-016 IDLE: one-hot sample -> LOCK with o_valid=1; invalid sample -> stay IDLE, o_valid=0, no error (start-up tolerance).
REQ-017 LOCK: advance -> TRACK; hold -> LOCK; invalid -> ERROR, code 01; skip -> ERROR, code 10.
REQ-018 TRACK: advance or hold -> TRACK; invalid -> ERROR, code 01; skip -> ERROR, code 10.
REQ-019 ERROR: in_q ignored, o_valid=0, o_err=1, o_phase and o_rot_cnt frozen; in_clr_err=1 -> IDLE, o_err=0, o_err_code=00.
REQ-020 o_rot_cnt SHALL increment by 1 only on an advance 1000->0001 while in TRACK, wrapping from 2^ROT_W-1 to 0 with no flag.
REQ-021 Only the first error SHALL set o_err_code; the code holds until in_clr_err.
REQ-022 in_clr_err outside ERROR SHALL have no effect.
REQ-023 When in_clr_err is asserted in ERROR, the state SHALL go to IDLE; the sample in that cycle is not classified.
REQ-024 in_clr_err SHALL NOT clear o_rot_cnt; only reset clears it.
REQ-025 On entering ERROR, o_valid SHALL drop in the same cycle that o_err rises.

Reset
REQ-026 While in_rst_n=0, outputs SHALL be: o_phase=0, o_valid=0, o_rot_cnt=0, o_err=0, o_err_code=00, o_state=IDLE; previous-sample register=0000.
REQ-027 Reset assertion SHALL take effect immediately regardless of in_clk, including mid-rotation and in ERROR.
REQ-028 After release, the first rising edge SHALL be treated as an IDLE sample.

Verification
REQ-029 Reset, then in_q=0000 for 3 cycles -> o_state=IDLE, o_valid=0, o_err=0.
REQ-030 Drive 0001,0010,0100,1000,0001 x3 rotations -> o_state=TRACK, o_phase follows 0,1,2,3,0, o_rot_cnt=3.
REQ-031 TRACK at 0010, drive 1000 -> next cycle o_state=ERROR, o_err=1, o_err_code=10, o_valid=0; then in_q=0110 -> code stays 10.
REQ-032 In ERROR, pulse in_clr_err for 1 cycle -> o_state=IDLE, o_err=0, o_err_code=00, o_rot_cnt unchanged; then 0001 -> LOCK.
REQ-033 ROT_W=2, drive 5 full rotations -> o_rot_cnt sequence 1,2,3,0,1.
REQ-034 Assert in_rst_n=0 mid-cycle during TRACK -> all outputs reach reset values before the next in_clk edge.
